// File: rtl/gcm_pkg.sv
// Shared types for the gcm input sequencer: block segment tags, FSM states
// and header field positions (field index times CNT_BITS gives the LSB).
package gcm_pkg;

  typedef enum logic [1:0] {
    SEG_IV   = 2'd0,
    SEG_AAD  = 2'd1,
    SEG_DATA = 2'd2
  } seg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IV,
    ST_AAD,
    ST_DATA,
    ST_DRAIN,
    ST_FLUSH
  } seq_state_t;

  localparam int unsigned HDR_P_FIELD = 0;
  localparam int unsigned HDR_A_FIELD = 1;

endpackage

// File: rtl/word_packer.sv
// Word-to-block shift register: first word of a block ends up in the top bits.
// blk_next is the completed block while `last` marks the block's final word.
module word_packer #(
  parameter int unsigned WORD_BITS = 32,
  parameter int unsigned BLK_BITS  = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 we,
  input  logic [WORD_BITS-1:0] word,
  output logic                 last,
  output logic [BLK_BITS-1:0]  blk_next
);

  localparam int unsigned WORDS   = BLK_BITS / WORD_BITS;
  localparam int unsigned SR_BITS = BLK_BITS - WORD_BITS;
  localparam int unsigned CW      = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [SR_BITS-1:0] sr;
  logic [CW-1:0]      cnt;

  assign last     = (cnt == CW'(WORDS - 1));
  assign blk_next = {sr, word};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
      sr  <= '0;
    end else if (we) begin
      cnt <= last ? '0 : cnt + CW'(1);
      sr  <= SR_BITS'({sr, word});
    end
  end

endmodule

// File: rtl/gcm_in_seq.sv
// Feeds gcm with IV, AAD and payload blocks packed from a 32-bit frame stream.
// Define GCM_IN_SEQ_BYTESWAP_EN to byte-reverse every accepted word (header too).
module gcm_in_seq
  import gcm_pkg::*;
#(
  parameter int unsigned WORD_BITS = 32,
  parameter int unsigned BLK_BITS  = 128,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [BLK_BITS-1:0]  gcm_in_blk,
  output logic                 gcm_valid,
  input  logic                 gcm_ready,
  output logic [1:0]           blk_seg,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_err
);

  seq_state_t state, state_nx;
  seg_t       out_seg, cur_seg;

  logic [WORD_BITS-1:0] word;
  logic [CNT_BITS-1:0]  a_cnt, p_cnt, blk_left, hdr_a, hdr_p;
  logic [BLK_BITS-1:0]  pk_blk;
  logic                 pk_last, aborted;
  logic                 word_acc, blk_acc, hdr_acc, in_blk_state;
  logic                 final_blk, blk_done, early, blk_load, missing;

`ifdef GCM_IN_SEQ_BYTESWAP_EN
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < WORD_BITS / 8; i++)
      word[i*8 +: 8] = s_axis_tdata[WORD_BITS-8-i*8 +: 8];
  end
`else
  assign word = s_axis_tdata;
`endif

  assign hdr_p = word[HDR_P_FIELD*CNT_BITS +: CNT_BITS];
  assign hdr_a = word[HDR_A_FIELD*CNT_BITS +: CNT_BITS];

  assign word_acc     = s_axis_tvalid && s_axis_tready;
  assign blk_acc      = gcm_valid && gcm_ready;
  assign hdr_acc      = word_acc && (state == ST_IDLE);
  assign in_blk_state = state inside {ST_IV, ST_AAD, ST_DATA};

  // Any tlast that is not on the final word of the final block aborts the frame.
  always_comb begin
    final_blk = 1'b0;
    cur_seg   = SEG_IV;
    unique case (state)
      ST_IV:   final_blk = (a_cnt == '0) && (p_cnt == '0);
      ST_AAD: begin
        final_blk = (blk_left == CNT_BITS'(1)) && (p_cnt == '0);
        cur_seg   = SEG_AAD;
      end
      ST_DATA: begin
        final_blk = (blk_left == CNT_BITS'(1));
        cur_seg   = SEG_DATA;
      end
      default: ;
    endcase
    blk_done = word_acc && in_blk_state && pk_last;
    early    = word_acc && in_blk_state && s_axis_tlast && !(pk_last && final_blk);
    blk_load = blk_done && !early;
    missing  = blk_done && final_blk && !s_axis_tlast;
  end

  word_packer #(
    .WORD_BITS(WORD_BITS),
    .BLK_BITS (BLK_BITS)
  ) u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear   (early),
    .we      (word_acc && in_blk_state),
    .word    (word),
    .last    (pk_last),
    .blk_next(pk_blk)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (hdr_acc) state_nx = s_axis_tlast ? ST_IDLE : ST_IV;
      ST_IV, ST_AAD, ST_DATA: begin
        if (early)
          state_nx = (gcm_valid && !gcm_ready) ? ST_DRAIN : ST_IDLE;
        else if (blk_done) begin
          if (final_blk)             state_nx = s_axis_tlast ? ST_DRAIN : ST_FLUSH;
          else if (state == ST_IV)   state_nx = (a_cnt != '0) ? ST_AAD : ST_DATA;
          else if (state == ST_AAD)  state_nx = (blk_left == CNT_BITS'(1)) ? ST_DATA : ST_AAD;
        end
      end
      ST_DRAIN: if (blk_acc) state_nx = ST_IDLE;
      ST_FLUSH: if (word_acc && s_axis_tlast) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    done          = 1'b0;
    frame_err     = 1'b0;
    busy          = 1'b0;
    if (!reset) begin
      unique case (state)
        ST_IDLE, ST_FLUSH:      s_axis_tready = 1'b1;
        ST_IV, ST_AAD, ST_DATA: s_axis_tready = !(pk_last && gcm_valid && !gcm_ready);
        default:                s_axis_tready = 1'b0;
      endcase
      done      = (state == ST_DRAIN) && blk_acc && !aborted;
      frame_err = (hdr_acc && s_axis_tlast) || early || missing;
      busy      = (state != ST_IDLE) || gcm_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_cnt    <= '0;
      p_cnt    <= '0;
      blk_left <= '0;
      aborted  <= 1'b0;
    end else begin
      if (hdr_acc) begin
        a_cnt   <= hdr_a;
        p_cnt   <= hdr_p;
        aborted <= 1'b0;
      end
      if (early) aborted <= 1'b1;
      if (blk_load && !final_blk) begin
        unique case (state)
          ST_IV:   blk_left <= (a_cnt != '0) ? a_cnt : p_cnt;
          ST_AAD:  blk_left <= (blk_left == CNT_BITS'(1)) ? p_cnt : blk_left - CNT_BITS'(1);
          ST_DATA: blk_left <= blk_left - CNT_BITS'(1);
          default: ;
        endcase
      end
    end
  end

  // A reload in the same cycle as a gcm accept keeps gcm_valid high (no bubble).
  always_ff @(posedge clk) begin
    if (reset) begin
      gcm_valid  <= 1'b0;
      gcm_in_blk <= '0;
      out_seg    <= SEG_IV;
    end else if (blk_load) begin
      gcm_valid  <= 1'b1;
      gcm_in_blk <= pk_blk;
      out_seg    <= cur_seg;
    end else if (gcm_ready) begin
      gcm_valid  <= 1'b0;
    end
  end

  assign blk_seg = out_seg;

endmodule

// File: tb/tb_gcm_in_seq.sv
// Directed bench for gcm_in_seq: block order/content, backpressure, framing errors, reset.
module tb_gcm_in_seq;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [127:0] gcm_in_blk;
  logic         gcm_valid;
  logic         gcm_ready = 1'b1;
  logic [1:0]   blk_seg;
  logic         busy, done, frame_err;

  gcm_in_seq #(.WORD_BITS(32), .BLK_BITS(128), .CNT_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .gcm_in_blk(gcm_in_blk), .gcm_valid(gcm_valid), .gcm_ready(gcm_ready),
    .blk_seg(blk_seg), .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_done = 0, n_err = 0, stall_4th = 0, stall_other = 0;
  int ready_mode = 0, wcnt = 0;
  logic ready_force = 1'b1;
  logic [127:0] q_blk[$];
  logic [1:0]   q_seg[$];
  logic [31:0]  f1w[28];
  logic [127:0] eb[7];
  logic [1:0]   es[7];

  // gcm_ready: forced level, or low for 10 cycles per presented block
  initial forever begin
    @(posedge clk); #1;
    if (ready_mode == 1) begin
      if (gcm_ready) begin gcm_ready = 1'b0; wcnt = 0; end
      else if (gcm_valid) begin wcnt++; if (wcnt >= 10) gcm_ready = 1'b1; end
    end else gcm_ready = ready_force;
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (gcm_valid && gcm_ready) begin q_blk.push_back(gcm_in_blk); q_seg.push_back(blk_seg); end
      if (done) n_done++;
      if (frame_err) n_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task clear_obs();
    q_blk.delete(); q_seg.delete();
    n_done = 0; n_err = 0; stall_4th = 0; stall_other = 0;
  endtask

  task send_word(input logic [31:0] d, input logic l, input int pos);
    int t;
    t = 0;
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && t < 300) begin
      if (pos % 4 == 3) stall_4th++; else stall_other++;
      t++;
      @(negedge clk);
    end
    if (!s_axis_tready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: tready=%b want 1", s_axis_tready);
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task wait_idle();
    int t;
    t = 0;
    repeat (2) @(negedge clk);
    while (busy && t < 3000) begin @(negedge clk); t++; end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task init_frame1();
    f1w[0] = 32'h3e894ebb; f1w[1] = 32'h16ce82a5; f1w[2] = 32'h3c3e05b2; f1w[3] = 32'h00000000;
    f1w[4] = 32'h00000000; f1w[5] = 32'h00000180; f1w[6] = 32'h00000000; f1w[7] = 32'h00000100;
    for (int i = 8; i < 20; i++) f1w[i] = 32'hAA00_0000 + 32'(i);
    for (int i = 20; i < 28; i++) f1w[i] = 32'hDD00_0000 + 32'(i);
    eb[0] = 128'h3e894ebb16ce82a53c3e05b200000000;
    eb[1] = 128'h00000000000001800000000000000100;
    for (int k = 2; k < 7; k++) eb[k] = {f1w[4*k], f1w[4*k+1], f1w[4*k+2], f1w[4*k+3]};
    es[0] = 2'd0; es[1] = 2'd1; es[2] = 2'd1; es[3] = 2'd1; es[4] = 2'd1; es[5] = 2'd2; es[6] = 2'd2;
  endtask

  task send_frame1();
    send_word(32'h0004_0002, 1'b0, -1);
    for (int i = 0; i < 28; i++) send_word(f1w[i], i == 27, i % 4);
  endtask

  task send_empty();
    send_word(32'h0000_0000, 1'b0, -1);
    send_word(32'h0123_4567, 1'b0, 0);
    send_word(32'h89ab_cdef, 1'b0, 1);
    send_word(32'h0f1e_2d3c, 1'b0, 2);
    send_word(32'h4b5a_6978, 1'b1, 3);
  endtask

  task test_reset();
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready: got %b want 0", s_axis_tready); end
    n_cmp++; if (gcm_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", gcm_valid); end
    n_cmp++; if (gcm_in_blk !== 128'h0) begin n_bad++; $display("FAIL rst_blk: got %h want 0", gcm_in_blk); end
    n_cmp++; if ({blk_seg, busy, done, frame_err} !== 5'b0) begin
      n_bad++; $display("FAIL rst_misc: got seg=%0d busy=%b done=%b err=%b want all 0", blk_seg, busy, done, frame_err);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL idle_tready: got %b want 1", s_axis_tready); end
  endtask

  task test_basic();
    clear_obs();
    send_frame1();
    wait_idle();
    n_cmp++; if (q_blk.size() != 7) begin n_bad++; $display("FAIL basic_count: got %0d want 7", q_blk.size()); end
    for (int i = 0; i < 7 && i < q_blk.size(); i++) begin
      n_cmp++;
      if (q_blk[i] !== eb[i] || q_seg[i] !== es[i]) begin
        n_bad++; $display("FAIL basic_blk%0d: got %h/%0d want %h/%0d", i, q_blk[i], q_seg[i], eb[i], es[i]);
      end
    end
    n_cmp++; if (n_done != 1 || n_err != 0) begin n_bad++; $display("FAIL basic_flags: got done=%0d err=%0d want 1/0", n_done, n_err); end
    n_cmp++; if (stall_4th + stall_other != 0) begin n_bad++; $display("FAIL basic_stall: got %0d want 0", stall_4th + stall_other); end
  endtask

  task test_backpressure();
    clear_obs();
    ready_mode = 1;
    send_frame1();
    wait_idle();
    ready_mode = 0;
    @(posedge clk); #1;
    n_cmp++; if (q_blk.size() != 7) begin n_bad++; $display("FAIL bp_count: got %0d want 7", q_blk.size()); end
    for (int i = 0; i < 7 && i < q_blk.size(); i++) begin
      n_cmp++;
      if (q_blk[i] !== eb[i] || q_seg[i] !== es[i]) begin
        n_bad++; $display("FAIL bp_blk%0d: got %h/%0d want %h/%0d", i, q_blk[i], q_seg[i], eb[i], es[i]);
      end
    end
    n_cmp++; if (n_done != 1 || n_err != 0) begin n_bad++; $display("FAIL bp_flags: got done=%0d err=%0d want 1/0", n_done, n_err); end
    n_cmp++; if (stall_other != 0) begin n_bad++; $display("FAIL bp_stall_other: got %0d want 0", stall_other); end
    n_cmp++; if (stall_4th == 0) begin n_bad++; $display("FAIL bp_stall_4th: got 0 want >0"); end
  endtask

  task test_empty();
    clear_obs();
    send_empty();
    wait_idle();
    n_cmp++; if (q_blk.size() != 1) begin n_bad++; $display("FAIL empty_count: got %0d want 1", q_blk.size()); end
    else begin
      n_cmp++;
      if (q_blk[0] !== 128'h0123456789abcdef0f1e2d3c4b5a6978 || q_seg[0] !== 2'd0) begin
        n_bad++; $display("FAIL empty_blk: got %h/%0d want 0123456789abcdef0f1e2d3c4b5a6978/0", q_blk[0], q_seg[0]);
      end
    end
    n_cmp++; if (n_done != 1 || n_err != 0) begin n_bad++; $display("FAIL empty_flags: got done=%0d err=%0d want 1/0", n_done, n_err); end
  endtask

  task test_early_tlast();
    clear_obs();
    send_word(32'h0001_0001, 1'b0, -1);
    for (int i = 0; i < 4; i++) send_word(32'h1111_0000 + 32'(i), 1'b0, i);
    for (int i = 0; i < 4; i++) send_word(32'h2222_0000 + 32'(i), 1'b0, i);
    send_word(32'h3333_0000, 1'b0, 0);
    send_word(32'h3333_0001, 1'b1, 1);
    wait_idle();
    n_cmp++; if (q_blk.size() != 2) begin n_bad++; $display("FAIL early_count: got %0d want 2", q_blk.size()); end
    else begin
      n_cmp++;
      if (q_blk[0] !== 128'h11110000111100011111000211110003 || q_seg[0] !== 2'd0) begin
        n_bad++; $display("FAIL early_iv: got %h/%0d want 11110000111100011111000211110003/0", q_blk[0], q_seg[0]);
      end
      n_cmp++;
      if (q_blk[1] !== 128'h22220000222200012222000222220003 || q_seg[1] !== 2'd1) begin
        n_bad++; $display("FAIL early_aad: got %h/%0d want 22220000222200012222000222220003/1", q_blk[1], q_seg[1]);
      end
    end
    n_cmp++; if (n_done != 0 || n_err != 1) begin n_bad++; $display("FAIL early_flags: got done=%0d err=%0d want 0/1", n_done, n_err); end
    test_empty();
  endtask

  task test_missing_tlast();
    clear_obs();
    send_word(32'h0000_0001, 1'b0, -1);
    for (int i = 0; i < 4; i++) send_word(32'h4444_0000 + 32'(i), 1'b0, i);
    for (int i = 0; i < 4; i++) send_word(32'h5555_0000 + 32'(i), 1'b0, i);
    for (int i = 0; i < 3; i++) send_word(32'h6666_0000 + 32'(i), i == 2, -1);
    wait_idle();
    n_cmp++; if (q_blk.size() != 2) begin n_bad++; $display("FAIL miss_count: got %0d want 2", q_blk.size()); end
    else begin
      n_cmp++;
      if (q_blk[1] !== 128'h55550000555500015555000255550003 || q_seg[1] !== 2'd2) begin
        n_bad++; $display("FAIL miss_data: got %h/%0d want 55550000555500015555000255550003/2", q_blk[1], q_seg[1]);
      end
    end
    n_cmp++; if (n_done != 0 || n_err != 1) begin n_bad++; $display("FAIL miss_flags: got done=%0d err=%0d want 0/1", n_done, n_err); end
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL miss_idle: got tready=%b want 1", s_axis_tready); end
  endtask

  task test_reset_mid();
    ready_force = 1'b0;
    repeat (2) @(posedge clk); #1;
    send_word(32'h0004_0002, 1'b0, -1);
    for (int i = 0; i < 4; i++) send_word(f1w[i], 1'b0, i);
    for (int i = 4; i < 6; i++) send_word(f1w[i], 1'b0, i % 4);
    n_cmp++; if (gcm_valid !== 1'b1) begin n_bad++; $display("FAIL mid_valid: got %b want 1", gcm_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (gcm_valid !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: got valid=%b busy=%b tready=%b want 0/0/0", gcm_valid, busy, s_axis_tready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ready_force = 1'b1;
    repeat (2) @(posedge clk); #1;
    test_empty();
  endtask

  initial begin
    init_frame1();
    test_reset();
    test_basic();
    test_backpressure();
    test_empty();
    test_early_tlast();
    test_missing_tlast();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
